// File: rtl/mult_arb_pkg.sv
// mult_arb_pkg: shared constants, ID-width helper and tag-stage type for mult_share_arbiter.
package mult_arb_pkg;
  localparam int MUL_LAT_DEF = 3;
  localparam int W_DEF = 8;
  localparam int ID_MAX_W = 3;
  function automatic int id_w(input int n);
    return (n > 2) ? $clog2(n) : 1;
  endfunction
  // Sized for the largest supported requester count; the top slices down to its own ID width.
  typedef struct packed {
    logic                valid;
    logic [ID_MAX_W-1:0] id;
  } tag_t;
endpackage

// File: rtl/rr_arbiter.sv
// rr_arbiter: combinational round-robin grant, highest priority at ptr, descending mod N.
module rr_arbiter #(
  parameter int N = 4,
  parameter int IW = 2
) (
  input  logic [N-1:0]  req,
  input  logic          en,
  input  logic [IW-1:0] ptr,
  output logic [N-1:0]  gnt,
  output logic          gnt_any,
  output logic [IW-1:0] gnt_id
);
  always_comb begin
    gnt_any = 1'b0;
    gnt_id = '0;
    // Scan from lowest priority upward so the highest-priority hit is written last.
    for (int k = N - 1; k >= 0; k--) begin
      if (en && req[(int'(ptr) + k) % N]) begin
        gnt_any = 1'b1;
        gnt_id = IW'((int'(ptr) + k) % N);
      end
    end
    gnt = gnt_any ? (N'(1) << gnt_id) : '0;
  end
endmodule

// File: rtl/mult_share_arbiter.sv
// mult_share_arbiter: round-robin sharing of one pipelined multiplier with ID-tagged results.
// Define MULT_ARB_OUT_REG_EN to register {res_valid, res_id, res_p} (latency MUL_LAT+1).
module mult_share_arbiter
  import mult_arb_pkg::*;
#(
  parameter int N_REQ = 4,
  parameter int W = W_DEF,
  parameter int MUL_LAT = MUL_LAT_DEF,
  localparam int IW = id_w(N_REQ)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               issue_en,
  input  logic [N_REQ-1:0]   req_valid,
  input  logic [N_REQ*W-1:0] req_a,
  input  logic [N_REQ*W-1:0] req_b,
  output logic [N_REQ-1:0]   req_ready,
  output logic [W-1:0]       mul_a,
  output logic [W-1:0]       mul_b,
  input  logic [2*W-1:0]     mul_p,
  output logic               res_valid,
  output logic [IW-1:0]      res_id,
  output logic [2*W-1:0]     res_p
);
  logic [IW-1:0] ptr;
  logic          gnt_any;
  logic [IW-1:0] gnt_id;
  tag_t          tags [MUL_LAT];
  logic          fin_v;
  logic [IW-1:0] fin_id;
  logic          unused_id_bits;

  rr_arbiter #(.N(N_REQ), .IW(IW)) u_arb (
    .req(req_valid),
    .en(issue_en & rst),
    .ptr(ptr),
    .gnt(req_ready),
    .gnt_any(gnt_any),
    .gnt_id(gnt_id)
  );

  assign mul_a = gnt_any ? req_a[gnt_id*W +: W] : '0;
  assign mul_b = gnt_any ? req_b[gnt_id*W +: W] : '0;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ptr <= '0;
      for (int s = 0; s < MUL_LAT; s++) tags[s] <= '0;
    end else begin
      if (gnt_any) ptr <= (gnt_id == IW'(N_REQ - 1)) ? '0 : gnt_id + 1'b1;
      tags[0] <= '{valid: gnt_any, id: ID_MAX_W'(gnt_id)};
      for (int s = 1; s < MUL_LAT; s++) tags[s] <= tags[s-1];
    end
  end

  assign fin_v = tags[MUL_LAT-1].valid;
  assign fin_id = tags[MUL_LAT-1].id[IW-1:0];
  assign unused_id_bits = ^tags[MUL_LAT-1].id;

`ifdef MULT_ARB_OUT_REG_EN
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      res_valid <= 1'b0;
      res_id <= '0;
      res_p <= '0;
    end else begin
      res_valid <= fin_v;
      res_id <= fin_id;
      res_p <= mul_p & {(2*W){fin_v}};
    end
  end
`else
  assign res_valid = fin_v;
  assign res_id = fin_id;
  assign res_p = mul_p & {(2*W){fin_v}};
`endif
endmodule

// File: tb/tb_mult_share_arbiter.sv
// tb_mult_share_arbiter: directed + random stimulus against a scoreboard of expected tagged products.
module tb_mult_share_arbiter;
  import mult_arb_pkg::*;
  localparam int N = 4;
  localparam int W = 8;
  localparam int LAT = 3;
`ifdef MULT_ARB_OUT_REG_EN
  localparam int RLAT = LAT + 1;
`else
  localparam int RLAT = LAT;
`endif
  localparam int IW = id_w(N);

  logic           clk = 1'b0;
  logic           rst = 1'b0;
  logic           issue_en = 1'b0;
  logic [N-1:0]   req_valid = '0;
  logic [N*W-1:0] req_a = '0;
  logic [N*W-1:0] req_b = '0;
  logic [N-1:0]   req_ready;
  logic [W-1:0]   mul_a, mul_b;
  logic [2*W-1:0] mul_p;
  logic           res_valid;
  logic [IW-1:0]  res_id;
  logic [2*W-1:0] res_p;
  logic [2*W-1:0] mp [LAT];

  typedef struct {int id; int p; int due;} exp_t;
  exp_t q[$];
  int cyc = 0, mptr = 0, last_g = -1, checks = 0, errors = 0;

  always #5 clk = ~clk;

  mult_share_arbiter #(.N_REQ(N), .W(W), .MUL_LAT(LAT)) dut (
    .clk(clk), .rst(rst), .issue_en(issue_en), .req_valid(req_valid),
    .req_a(req_a), .req_b(req_b), .req_ready(req_ready), .mul_a(mul_a),
    .mul_b(mul_b), .mul_p(mul_p), .res_valid(res_valid), .res_id(res_id), .res_p(res_p)
  );

  // Stand-in for the shared pipelined multiplier, reset by the same net.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int s = 0; s < LAT; s++) mp[s] <= '0;
    end else begin
      mp[0] <= {8'b0, mul_a} * {8'b0, mul_b};
      for (int s = 1; s < LAT; s++) mp[s] <= mp[s-1];
    end
  end
  assign mul_p = mp[LAT-1];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s obs=%0d exp=%0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    int g, ea, eb, ev, eid, ep;
    logic [N-1:0] er;
    @(negedge clk);
    g = -1;
    if (rst && issue_en)
      for (int k = 0; k < N; k++)
        if (g < 0 && req_valid[(mptr + k) % N]) g = (mptr + k) % N;
    er = '0;
    ea = 0;
    eb = 0;
    if (g >= 0) begin
      er[g] = 1'b1;
      ea = int'(req_a[g*W +: W]);
      eb = int'(req_b[g*W +: W]);
    end
    chk("req_ready", 32'(req_ready), 32'(er));
    chk("mul_a", 32'(mul_a), ea);
    chk("mul_b", 32'(mul_b), eb);
    if (!rst) q.delete();
    ev = 0;
    eid = 0;
    ep = 0;
    if (q.size() > 0 && q[0].due == cyc) begin
      ev = 1;
      eid = q[0].id;
      ep = q[0].p;
      void'(q.pop_front());
    end
    chk("res_valid", 32'(res_valid), ev);
    chk("res_id", 32'(res_id), eid);
    chk("res_p", 32'(res_p), ep);
    @(posedge clk);
    cyc++;
    if (!rst) mptr = 0;
    else if (g >= 0) begin
      q.push_back('{g, ea * eb, cyc - 1 + RLAT});
      mptr = (g + 1) % N;
    end
    last_g = g;
    #1;
  endtask

  task automatic set_op(input int i, input int a, input int b);
    req_a[i*W +: W] = W'(a);
    req_b[i*W +: W] = W'(b);
    req_valid[i] = 1'b1;
  endtask

  task automatic do_reset();
    rst = 1'b0;
    tick();
    rst = 1'b1;
  endtask

  initial begin
    int ops [4][2];
    ops = '{'{15, 10}, '{25, 12}, '{50, 20}, '{100, 5}};
    tick();
    tick();
    rst = 1'b1;
    issue_en = 1'b1;
    // Single request from requester 0.
    set_op(0, 15, 10);
    tick();
    chk("single_gnt", last_g, 0);
    req_valid = '0;
    repeat (RLAT + 2) tick();
    // All four from reset: strict 0,1,2,3 ordering.
    do_reset();
    for (int i = 0; i < N; i++) set_op(i, ops[i][0], ops[i][1]);
    for (int i = 0; i < N; i++) begin
      tick();
      chk("rr_order", last_g, i);
      if (last_g >= 0) req_valid[last_g] = 1'b0;
    end
    repeat (RLAT + 2) tick();
    // Two contenders held valid: strict alternation.
    set_op(0, 7, 9);
    set_op(2, 11, 13);
    for (int i = 0; i < 8; i++) begin
      tick();
      chk("alt", last_g, (i % 2) * 2);
      if (last_g >= 0) set_op(last_g, $urandom_range(0, 255), $urandom_range(0, 255));
    end
    req_valid = '0;
    repeat (RLAT + 2) tick();
    // Issue gating.
    issue_en = 1'b0;
    set_op(1, 200, 3);
    repeat (RLAT + 2) tick();
    chk("gated_q", q.size(), 0);
    issue_en = 1'b1;
    tick();
    chk("ungated", last_g, 1);
    req_valid = '0;
    set_op(3, 255, 255);
    tick();
    req_valid = '0;
    repeat (RLAT + 2) tick();
    // Reset with ops in flight: nothing emerges, pointer restarts.
    for (int i = 0; i < 3; i++) set_op(i, 20 + i, 30 + i);
    repeat (3) begin
      tick();
      if (last_g >= 0) req_valid[last_g] = 1'b0;
    end
    do_reset();
    req_valid = '0;
    repeat (RLAT + 2) tick();
    set_op(1, 3, 4);
    set_op(3, 5, 6);
    tick();
    chk("post_rst", last_g, 1);
    req_valid = '0;
    repeat (RLAT + 2) tick();
    // Random traffic: requesters hold operands until transfer, occasionally withdraw.
    for (int c = 0; c < 400; c++) begin
      issue_en = ($urandom_range(0, 7) != 0);
      for (int i = 0; i < N; i++) begin
        if (!req_valid[i] && $urandom_range(0, 2) == 0)
          set_op(i, ($urandom_range(0, 7) == 0) ? 255 : $urandom_range(0, 255),
                    ($urandom_range(0, 7) == 0) ? 0 : $urandom_range(0, 255));
        else if (req_valid[i] && $urandom_range(0, 15) == 0)
          req_valid[i] = 1'b0;
      end
      if (c == 200) rst = 1'b0;
      if (c == 201) rst = 1'b1;
      tick();
      if (last_g >= 0) req_valid[last_g] = 1'b0;
    end
    rst = 1'b1;
    issue_en = 1'b0;
    repeat (RLAT + 3) tick();
    chk("drain", q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
